// File: rtl/seq_detector_if.sv
// Serial pattern-detector bus.
// Groups the serial input stream, the counter clear and the detector results so the
// detector and its driver share one connection.
//   Din, Din_valid  : serial data bit and its qualifier (master -> slave)
//   Clr_cnt         : synchronous clear of the match counter (master -> slave)
//   Detect          : registered one-cycle match pulse (slave -> master)
//   Match_count     : saturating match counter, CNT_W bits (slave -> master)
//   Fill            : valid bits currently held in the window (slave -> master)
interface seq_detector_if #(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 8
) ();
    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

    logic              Din;
    logic              Din_valid;
    logic              Clr_cnt;
    logic              Detect;
    logic [CNT_W-1:0]  Match_count;
    logic [FILL_W-1:0] Fill;

    modport master (
        output Din,
        output Din_valid,
        output Clr_cnt,
        input  Detect,
        input  Match_count,
        input  Fill
    );

    modport slave (
        input  Din,
        input  Din_valid,
        input  Clr_cnt,
        output Detect,
        output Match_count,
        output Fill
    );
endinterface

// File: rtl/seq_detector.sv
// Serial bit-pattern detector.
// Shifts qualified serial bits into a PAT_LEN-bit history window (oldest bit at the MSB)
// and pulses Detect for one cycle when a full window equals PATTERN. Matches are counted
// in a saturating counter. With OVERLAP=0 the window is emptied on a match so matched bits
// are never reused.
//   Clk  : rising-edge clock
//   Rst  : synchronous active-high reset, overrides every other input
//   bus  : seq_detector_if slave modport (Din, Din_valid, Clr_cnt in;
//          Detect, Match_count, Fill out)
module seq_detector #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    seq_detector_if.slave bus
);
    localparam int unsigned       FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_q, det_d;

    logic [FILL_W-1:0]  fill_nxt;
    logic               match;

    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        det_d    = 1'b0;
        fill_nxt = fill_q;
        match    = 1'b0;

        // Din is only looked at when qualified, so X on an idle cycle never propagates.
        if (bus.Din_valid) begin
            hist_d   = {hist_q[PAT_LEN-2:0], bus.Din};
            fill_nxt = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
            // The match is judged on the post-shift window so the pulse lands on the
            // edge that samples the final pattern bit.
            match    = (fill_nxt == FILL_FULL) && (hist_d == PATTERN);
            fill_d   = (match && !OVERLAP) ? '0 : fill_nxt;
            det_d    = match;
        end

        // A clear coinciding with a match counts that match.
        if (bus.Clr_cnt) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            det_q  <= det_d;
        end
    end

    assign bus.Detect      = det_q;
    assign bus.Match_count = cnt_q;
    assign bus.Fill        = fill_q;

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector. Three instances share one stimulus stream:
//   dut_a : defaults (OVERLAP=1, CNT_W=8)
//   dut_b : OVERLAP=0
//   dut_c : CNT_W=2, otherwise defaults (its count is dut_a's count capped at 3)
module tb_seq_detector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, din, vld, clr;

    seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if_a ();
    seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if_b ();
    seq_detector_if #(.PAT_LEN(4), .CNT_W(2)) if_c ();

    assign if_a.Din = din;  assign if_a.Din_valid = vld;  assign if_a.Clr_cnt = clr;
    assign if_b.Din = din;  assign if_b.Din_valid = vld;  assign if_b.Clr_cnt = clr;
    assign if_c.Din = din;  assign if_c.Din_valid = vld;  assign if_c.Clr_cnt = clr;

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .Clk(clk), .Rst(rst), .bus(if_a));
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .Clk(clk), .Rst(rst), .bus(if_b));
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .Clk(clk), .Rst(rst), .bus(if_c));

    typedef struct {
        logic rst, din, vld, clr;
        logic da; int ca, fa;
        logic db; int cb, fb;
    } vec_t;

    typedef struct {
        int   row;
        logic vld;
        logic da; int ca, fa;
        logic db; int cb, fb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic prev_det_b = 1'b0;

    task automatic add(input logic r, input logic d, input logic v, input logic c,
                       input logic da, input int ca, input int fa,
                       input logic db, input int cb, input int fb);
        vec_t t;
        t.rst = r; t.din = d; t.vld = v; t.clr = c;
        t.da = da; t.ca = ca; t.fa = fa;
        t.db = db; t.cb = cb; t.fb = fb;
        vecs.push_back(t);
    endtask

    task automatic chk(input string what, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL row %0d %s: got %0d expected %0d", row, what, act, exp);
        end
    endtask

    // Scoreboard consumer: outputs are sampled 1 time unit after the edge that
    // consumed the matching stimulus.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("A detect", mon_e.row, {31'b0, if_a.Detect}, {31'b0, mon_e.da});
            chk("A count",  mon_e.row, {24'b0, if_a.Match_count}, mon_e.ca);
            chk("A fill",   mon_e.row, {29'b0, if_a.Fill}, mon_e.fa);
            chk("B detect", mon_e.row, {31'b0, if_b.Detect}, {31'b0, mon_e.db});
            chk("B count",  mon_e.row, {24'b0, if_b.Match_count}, mon_e.cb);
            chk("B fill",   mon_e.row, {29'b0, if_b.Fill}, mon_e.fb);
            chk("C detect", mon_e.row, {31'b0, if_c.Detect}, {31'b0, mon_e.da});
            chk("C count",  mon_e.row, {30'b0, if_c.Match_count},
                (mon_e.ca > 3) ? 3 : mon_e.ca);
            chk("C fill",   mon_e.row, {29'b0, if_c.Fill}, mon_e.fa);

            checks++;
            assert (!(if_b.Detect && prev_det_b))
            else begin
                failures++;
                $display("FAIL row %0d B detect two cycles: got 1,1 expected never", mon_e.row);
            end
            checks++;
            assert (mon_e.vld || !(if_a.Detect || if_b.Detect || if_c.Detect))
            else begin
                failures++;
                $display("FAIL row %0d detect after idle edge: got A%0d B%0d C%0d expected 0",
                         mon_e.row, if_a.Detect, if_b.Detect, if_c.Detect);
            end
        end
        prev_det_b <= if_b.Detect;
    end

    initial begin
        exp_t e;
        rst = 1'b1; din = 1'b0; vld = 1'b0; clr = 1'b0;

        // Stream 1,0,1,1,0,1,1: overlapping vs non-overlapping.
        add(1, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0,  0, 0, 1,  0, 0, 1);
        add(0, 0, 1, 0,  0, 0, 2,  0, 0, 2);
        add(0, 1, 1, 0,  0, 0, 3,  0, 0, 3);
        add(0, 1, 1, 0,  1, 1, 4,  1, 1, 0);
        add(0, 0, 1, 0,  0, 1, 4,  0, 1, 1);
        add(0, 1, 1, 0,  0, 1, 4,  0, 1, 2);
        add(0, 1, 1, 0,  1, 2, 4,  0, 1, 3);

        // Reset beats a valid sample; then 1,0, idle gap with toggling/X data, then 1,1.
        add(1, 1, 1, 0,  0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0,  0, 0, 1,  0, 0, 1);
        add(0, 0, 1, 0,  0, 0, 2,  0, 0, 2);
        add(0, 1, 0, 0,  0, 0, 2,  0, 0, 2);
        add(0, 1'bx, 0, 0, 0, 0, 2, 0, 0, 2);
        add(0, 0, 0, 0,  0, 0, 2,  0, 0, 2);
        add(0, 1, 1, 0,  0, 0, 3,  0, 0, 3);
        add(0, 1, 1, 0,  1, 1, 4,  1, 1, 0);

        // Reset mid-pattern (with valid and clear also high), then a fresh 1,0,1,1.
        add(1, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0,  0, 0, 1,  0, 0, 1);
        add(0, 0, 1, 0,  0, 0, 2,  0, 0, 2);
        add(0, 1, 1, 0,  0, 0, 3,  0, 0, 3);
        add(1, 1, 1, 1,  0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0,  0, 0, 1,  0, 0, 1);
        add(0, 0, 1, 0,  0, 0, 2,  0, 0, 2);
        add(0, 1, 1, 0,  0, 0, 3,  0, 0, 3);
        add(0, 1, 1, 0,  1, 1, 4,  1, 1, 0);

        // Five overlapping matches (C saturates at 3), then clear with a coincident match.
        add(1, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0,  0, 0, 1,  0, 0, 1);
        add(0, 0, 1, 0,  0, 0, 2,  0, 0, 2);
        add(0, 1, 1, 0,  0, 0, 3,  0, 0, 3);
        add(0, 1, 1, 0,  1, 1, 4,  1, 1, 0);
        add(0, 0, 1, 0,  0, 1, 4,  0, 1, 1);
        add(0, 1, 1, 0,  0, 1, 4,  0, 1, 2);
        add(0, 1, 1, 0,  1, 2, 4,  0, 1, 3);
        add(0, 0, 1, 0,  0, 2, 4,  0, 1, 4);
        add(0, 1, 1, 0,  0, 2, 4,  0, 1, 4);
        add(0, 1, 1, 0,  1, 3, 4,  1, 2, 0);
        add(0, 0, 1, 0,  0, 3, 4,  0, 2, 1);
        add(0, 1, 1, 0,  0, 3, 4,  0, 2, 2);
        add(0, 1, 1, 0,  1, 4, 4,  0, 2, 3);
        add(0, 0, 1, 0,  0, 4, 4,  0, 2, 4);
        add(0, 1, 1, 0,  0, 4, 4,  0, 2, 4);
        add(0, 1, 1, 0,  1, 5, 4,  1, 3, 0);
        add(0, 0, 1, 0,  0, 5, 4,  0, 3, 1);
        add(0, 1, 1, 0,  0, 5, 4,  0, 3, 2);
        add(0, 1, 1, 1,  1, 1, 4,  0, 0, 3);
        add(0, 1, 0, 1,  0, 0, 4,  0, 0, 3);
        add(0, 0, 1, 0,  0, 0, 4,  0, 0, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; din = vecs[i].din; vld = vecs[i].vld; clr = vecs[i].clr;
            e.row = i;       e.vld = vecs[i].vld;
            e.da = vecs[i].da; e.ca = vecs[i].ca; e.fa = vecs[i].fa;
            e.db = vecs[i].db; e.cb = vecs[i].cb; e.fb = vecs[i].fb;
            sb.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0; vld = 1'b0; clr = 1'b0; din = 1'b0;

        // Bounded drain of the scoreboard.
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
